// File: rtl/orion_ram_arbiter.sv
// Arbiter for the shared 1M x 16 main RAM: video bursts have priority, CPU byte accesses are
// stretched via wait_n, and bounded starvation guarantees the CPU a slot.
`timescale 1ns/1ps
module orion_ram_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned VID_BURST  = 4,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic              i_cpu_hi,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_wait_n,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [15:0]       o_vid_rdata,
  output logic              o_vid_valid,
  output logic              o_vid_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [1:0]        o_ram_be,
  output logic [15:0]       o_ram_wdata,
  input  logic [15:0]       i_ram_rdata
);

  localparam int unsigned BeatW   = (VID_BURST > 1) ? $clog2(VID_BURST) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [BeatW-1:0]   BeatLast  = BeatW'(VID_BURST - 1);
  localparam logic [BeatW-1:0]   BeatOne   = BeatW'(1);
  localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);
  localparam logic [StarveW-1:0] StarveOne = StarveW'(1);

  typedef enum logic [2:0] {StIdle, StVidAddr, StVidLast, StCpuAcc, StCpuDone} state_e;

  state_e              state;
  logic [ADDR_W-1:0]   vid_base;
  logic [BeatW-1:0]    beat_cnt;
  logic [StarveW-1:0]  starve_cnt;
  logic                cpu_block;
  logic                cpu_rd;
  logic                cpu_hi;
  logic [7:0]          rdata_hold;
  logic [7:0]          cpu_byte;
  logic                cpu_pend;
  logic                vid_win;

  // A held request must not be served twice: ignore it in the IDLE cycle right after an ack.
  assign cpu_pend = i_cpu_req & ~cpu_block;
  assign vid_win  = i_vid_req & (~cpu_pend | (starve_cnt < StarveTop));

  assign o_cpu_wait_n = ~(i_cpu_req & ~o_cpu_ack);
  assign cpu_byte     = cpu_hi ? i_ram_rdata[15:8] : i_ram_rdata[7:0];

  // The RAM output register is the data register: read data is steered, not re-registered,
  // so it lines up with ack/valid. The CPU byte is then held until the next ack.
  assign o_cpu_rdata = (o_cpu_ack && cpu_rd) ? cpu_byte : rdata_hold;
  assign o_vid_rdata = o_vid_valid ? i_ram_rdata : 16'h0000;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= StIdle;
      vid_base    <= '0;
      beat_cnt    <= '0;
      starve_cnt  <= '0;
      cpu_block   <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_hi      <= 1'b0;
      rdata_hold  <= 8'h00;
      o_cpu_ack   <= 1'b0;
      o_vid_valid <= 1'b0;
      o_vid_done  <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_we    <= 1'b0;
      o_ram_be    <= 2'b00;
      o_ram_wdata <= 16'h0000;
    end else begin
      o_ram_we    <= 1'b0;
      o_cpu_ack   <= 1'b0;
      o_vid_valid <= 1'b0;
      o_vid_done  <= 1'b0;
      cpu_block   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (vid_win) begin
            state      <= StVidAddr;
            vid_base   <= i_vid_addr;
            beat_cnt   <= '0;
            o_ram_addr <= i_vid_addr;
            o_ram_be   <= 2'b11;
          end else if (cpu_pend) begin
            state       <= StCpuAcc;
            o_ram_addr  <= i_cpu_addr;
            o_ram_be    <= i_cpu_hi ? 2'b10 : 2'b01;
            o_ram_we    <= i_cpu_we;
            o_ram_wdata <= {i_cpu_wdata, i_cpu_wdata};
            cpu_rd      <= ~i_cpu_we;
            cpu_hi      <= i_cpu_hi;
          end
        end
        StVidAddr: begin
          // Word for this address arrives next cycle, so valid is flagged one cycle behind.
          o_vid_valid <= 1'b1;
          if (beat_cnt == BeatLast) begin
            state      <= StVidLast;
            o_vid_done <= 1'b1;
          end else begin
            beat_cnt   <= beat_cnt + BeatOne;
            o_ram_addr <= vid_base + ADDR_W'(beat_cnt) + ADDR_W'(1);
          end
        end
        StVidLast: begin
          state    <= StIdle;
          o_ram_be <= 2'b00;
          if (!i_cpu_req) begin
            starve_cnt <= '0;
          end else if (starve_cnt < StarveTop) begin
            starve_cnt <= starve_cnt + StarveOne;
          end
        end
        StCpuAcc: begin
          state     <= StCpuDone;
          o_ram_be  <= 2'b00;
          o_cpu_ack <= 1'b1;
        end
        StCpuDone: begin
          state      <= StIdle;
          starve_cnt <= '0;
          cpu_block  <= 1'b1;
          if (cpu_rd) rdata_hold <= cpu_byte;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_orion_ram_arbiter.sv
// Randomized self-checking bench for orion_ram_arbiter: RAM array model plus a
// transaction-level shadow memory and grant-order model.
`timescale 1ns/1ps
module tb_orion_ram_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned VB = 4;
  localparam int unsigned SM = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_hi;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_wait_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_rdata;
  logic          vid_valid, vid_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [15:0]   ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  orion_ram_arbiter #(.ADDR_W(AW), .VID_BURST(VB), .STARVE_MAX(SM)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_hi(cpu_hi), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
    .o_cpu_wait_n(cpu_wait_n), .i_vid_req(vid_req), .i_vid_addr(vid_addr),
    .o_vid_rdata(vid_rdata), .o_vid_valid(vid_valid), .o_vid_done(vid_done),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_be(ram_be), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [15:0] init_word(input logic [AW-1:0] a);
    return {8'(a[7:0] ^ 8'h5C), 8'(a[15:8] ^ a[19:12] ^ 8'hA3)};
  endfunction

  // RAM array: synchronous read, one cycle latency, byte-lane writes.
  bit [15:0] ram [0:(1<<AW)-1];
  bit [1:0]  ram_vld [0:(1<<AW)-1];
  // Shadow: what each word should hold, updated per completed CPU write.
  bit [15:0] shadow [0:(1<<AW)-1];
  bit [1:0]  shadow_vld [0:(1<<AW)-1];

  function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
    logic [15:0] d = init_word(a);
    if (ram_vld[a][1]) d[15:8] = ram[a][15:8];
    if (ram_vld[a][0]) d[7:0]  = ram[a][7:0];
    return d;
  endfunction

  function automatic logic [15:0] expect_word(input logic [AW-1:0] a);
    logic [15:0] d = init_word(a);
    if (shadow_vld[a][1]) d[15:8] = shadow[a][15:8];
    if (shadow_vld[a][0]) d[7:0]  = shadow[a][7:0];
    return d;
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_be[1]) begin
        ram[ram_addr][15:8]  <= ram_wdata[15:8];
        ram_vld[ram_addr][1] <= 1'b1;
      end
      if (ram_be[0]) begin
        ram[ram_addr][7:0]   <= ram_wdata[7:0];
        ram_vld[ram_addr][0] <= 1'b1;
      end
    end
    ram_rdata <= ram_word(ram_addr);
  end

  int n_checks = 0;
  int n_errors = 0;
  int order_q[$];  // completion log: 1 = video burst, 0 = CPU access

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One CPU access; exp_lat < 0 skips the latency check.
  task automatic cpu_access(input bit we, input bit hi, input logic [AW-1:0] addr,
                            input logic [7:0] wd, input int exp_lat, output logic [7:0] rd);
    logic [AW-1:0] p_addr;
    logic [1:0]    p_be;
    logic          p_we;
    logic [15:0]   p_wd;
    logic [15:0]   exp_w;
    int            lat = 0;
    bit            got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_hi = hi; cpu_addr = addr; cpu_wdata = wd;
    rd = 8'h00;
    while (!got && lat < 60) begin
      p_addr = ram_addr; p_be = ram_be; p_we = ram_we; p_wd = ram_wdata;
      @(posedge clk); #1;
      lat++;
      if (cpu_ack) got = 1'b1;
      else check_eq("cpu_wait_n_low", cpu_wait_n, 1'b0);
    end
    check_eq("cpu_ack_seen", got, 1'b1);
    if (got) begin
      check_eq("cpu_wait_n_at_ack", cpu_wait_n, 1'b1);
      check_eq("cpu_ram_addr", p_addr, addr);
      check_eq("cpu_ram_be", p_be, hi ? 2'b10 : 2'b01);
      check_eq("cpu_ram_we", p_we, we);
      if (exp_lat >= 0) check_eq("cpu_latency", lat, exp_lat);
      exp_w = expect_word(addr);
      if (we) begin
        check_eq("cpu_ram_wdata_lane", hi ? p_wd[15:8] : p_wd[7:0], wd);
        if (hi) shadow[addr][15:8] = wd;
        else    shadow[addr][7:0]  = wd;
        shadow_vld[addr][hi] = 1'b1;
      end else begin
        rd = cpu_rdata;
        check_eq("cpu_rdata", cpu_rdata, hi ? exp_w[15:8] : exp_w[7:0]);
      end
      order_q.push_back(0);
    end
    cpu_req = 1'b0;
    tick(1);
    check_eq("cpu_ack_single", cpu_ack, 1'b0);
    if (got && !we) check_eq("cpu_rdata_held", cpu_rdata, rd);
    tick(1);
  endtask

  task automatic vid_burst(input logic [AW-1:0] base, input bit drop_early);
    logic [AW-1:0] p_addr;
    logic [AW-1:0] exp_a;
    int            beats = 0;
    int            cyc = 0;
    bit            done = 1'b0;
    vid_req = 1'b1; vid_addr = base;
    while (!done && cyc < 80) begin
      p_addr = ram_addr;
      @(posedge clk); #1;
      cyc++;
      if (vid_valid) begin
        exp_a = base + AW'(beats);
        check_eq("vid_ram_addr", p_addr, exp_a);
        check_eq("vid_rdata", vid_rdata, expect_word(exp_a));
        check_eq("vid_done_flag", vid_done, (beats == VB - 1) ? 1'b1 : 1'b0);
        beats++;
        if (vid_done) done = 1'b1;
        if (drop_early) vid_req = 1'b0;
      end else begin
        check_eq("vid_done_without_valid", vid_done, 1'b0);
      end
    end
    check_eq("vid_done_seen", done, 1'b1);
    check_eq("vid_beat_count", beats, VB);
    if (done) order_q.push_back(1);
    vid_req = 1'b0;
  endtask

  logic [AW-1:0] pool [4];
  logic [7:0]    rd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [15:0]   w;
    int            starve;
    bit            hi;
    pool[0] = 20'h00123; pool[1] = 20'h40000; pool[2] = 20'hFFFFF; pool[3] = 20'h0ABCD;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_hi = 1'b0; cpu_addr = '0;
    cpu_wdata = 8'h00; vid_req = 1'b0; vid_addr = '0;

    // Reset state
    #12;
    check_eq("rst_ack", cpu_ack, 1'b0);
    check_eq("rst_vid_valid", vid_valid, 1'b0);
    check_eq("rst_vid_done", vid_done, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_ram_be", ram_be, 2'b00);
    check_eq("rst_ram_addr", ram_addr, '0);
    check_eq("rst_cpu_rdata", cpu_rdata, 8'h00);
    check_eq("rst_wait_n_idle", cpu_wait_n, 1'b1);
    cpu_req = 1'b1; #1;
    check_eq("rst_wait_n_req", cpu_wait_n, 1'b0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // CPU write then reads of both planes
    cpu_access(1'b1, 1'b1, 20'h00123, 8'hA5, 2, rd);
    cpu_access(1'b0, 1'b1, 20'h00123, 8'h00, 2, rd);
    check_eq("t1_read_back_a5", rd, 8'hA5);
    cpu_access(1'b0, 1'b0, 20'h00123, 8'h00, 2, rd);
    w = init_word(20'h00123);
    check_eq("t1_lo_plane_untouched", rd, w[7:0]);

    // Wrapping video burst, then a burst whose request drops after the first beat
    vid_burst(20'hFFFFE, 1'b0);
    tick(1);
    vid_burst(20'h00120, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("vid_idle_after_burst", vid_valid, 1'b0);
    end
    cpu_access(1'b0, 1'b1, 20'h00123, 8'h00, 2, rd);

    // Random standalone traffic over a small address pool
    for (int i = 0; i < 12; i++) begin
      a = pool[$urandom_range(0, 3)];
      cpu_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom), 2, rd);
    end
    for (int i = 0; i < 3; i++) begin
      vid_burst(pool[$urandom_range(0, 3)] - AW'($urandom_range(0, 3)), 1'b0);
      tick(1);
    end

    // Simultaneous first request: video wins, CPU acked burst+3 cycles later
    order_q.delete();
    hi = 1'($urandom_range(0, 1));
    fork
      vid_burst(pool[1], 1'b0);
      cpu_access(1'b0, hi, pool[0], 8'h00, VB + 4, rd);
    join
    check_eq("t4_order_len", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check_eq("t4_first_video", order_q[0], 1);
      check_eq("t4_then_cpu", order_q[1], 0);
    end

    // Continuous contention: grant order follows the starvation limit
    order_q.delete();
    fork
      for (int i = 0; i < 3; i++) begin
        logic [7:0] r;
        cpu_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pool[$urandom_range(0, 3)], 8'($urandom), -1, r);
      end
      for (int i = 0; i < 2 * 3; i++) vid_burst(AW'($urandom), 1'b0);
    join
    check_eq("t3_order_len", order_q.size(), 9);
    starve = 0;
    for (int i = 0; i < 9 && i < order_q.size(); i++) begin
      if (starve < SM) begin
        check_eq("t3_grant_order", order_q[i], 1);
        starve++;
      end else begin
        check_eq("t3_grant_order", order_q[i], 0);
        starve = 0;
      end
    end

    // Reset during the RAM cycle of a CPU write
    a = pool[3];
    w = expect_word(a);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hi = 1'b1; cpu_addr = a; cpu_wdata = ~w[15:8];
    tick(1);
    check_eq("t5_we_in_acc", ram_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_we_async_drop", ram_we, 1'b0);
    check_eq("t5_no_ack", cpu_ack, 1'b0);
    check_eq("t5_vid_valid", vid_valid, 1'b0);
    check_eq("t5_wait_n_in_reset", cpu_wait_n, 1'b0);
    cpu_req = 1'b0;
    tick(1);
    check_eq("t5_no_ack_later", cpu_ack, 1'b0);
    rst_n = 1'b1;
    tick(1);
    cpu_access(1'b0, 1'b1, a, 8'h00, 2, rd);
    check_eq("t5_no_write_landed", rd, w[15:8]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
